negedge_counter_run_controller: RTL

- Sequences a negative-edge WIDTH-bit up counter through bounded runs.
- A requester issues START with a terminal value LIMIT and a MODE. The block then runs the count 0..LIMIT, supports PAUSE and STOP, and signals completion (one-shot) or wrap (auto-reload).
- Sits between lab control logic and the counter datapath. It owns the counter's clear and enable and exposes the count bus.

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/negedge_counter_core.sv | 26 ++
 rtl/negedge_counter_run_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the falling-edge counter run controller: FSM states and run modes.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/negedge_counter_core.sv
// Falling-edge up counter with synchronous clear/enable and async active-low reset.
module negedge_counter_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             CLR,
  input  logic             EN,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(negedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      cnt_q <= '0;
    end else if (CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Q = cnt_q;

endmodule

// File: rtl/negedge_counter_run_controller.sv
// Sequences a falling-edge counter through bounded one-shot or auto-reload runs
// with pause/stop; owns the counter's clear and enable and does the limit compare.
module negedge_counter_run_controller
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRAP
);

  state_e           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;

  // Compare happens before the increment, so LIMIT = all-ones never overflows.
  assign at_limit = (Q == limit_q);

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: cnt_clr = 1'b1;
      RUN: begin
        if (STOP) begin
          cnt_clr = 1'b1;
        end else if (PAUSE) begin
          cnt_en = 1'b0;
        end else if (!at_limit) begin
          cnt_en = 1'b1;
        end else if (mode_q == MODE_RELOAD) begin
          cnt_clr = 1'b1;
        end
      end
      HOLD: cnt_clr = STOP;
      FIN:  cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(negedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      state_q <= IDLE;
      limit_q <= '0;
      mode_q  <= MODE_ONESHOT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START && !STOP) begin
            limit_q <= LIMIT;
            mode_q  <= MODE;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (STOP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (PAUSE) begin
            state_q <= HOLD;
          end else if (at_limit) begin
            if (mode_q == MODE_RELOAD) begin
              wrap_q <= 1'b1;
            end else begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (STOP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!PAUSE) begin
            state_q <= RUN;
          end
        end
        FIN: begin
          // Back-to-back runs: a START present during FIN re-arms immediately.
          if (START && !STOP) begin
            limit_q <= LIMIT;
            mode_q  <= MODE;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  negedge_counter_core #(.WIDTH(WIDTH)) u_core (
    .CLK     (CLK),
    .not_RST (not_RST),
    .CLR     (cnt_clr),
    .EN      (cnt_en),
    .Q       (Q)
  );

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign WRAP = wrap_q;

endmodule
